// File: rtl/arb_pkg.sv
// Shared definitions for the memory arbiter: controller states and
// arbitration mode selectors.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } arb_state_t;

    localparam int unsigned ARB_RR    = 0;
    localparam int unsigned ARB_FIXED = 1;

endpackage

// File: rtl/rr_select.sv
// Combinational grant selection: round-robin from last_grant+1 upward,
// or fixed priority where the lowest requesting index wins.
module rr_select
    import arb_pkg::*;
#(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned MODE   = ARB_RR,
    localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  last_grant,
    output logic [IDX_W-1:0]  grant_idx,
    output logic              grant_valid
);

    int unsigned cand;

    // Both searches scan from the least preferred candidate to the most
    // preferred one, so the last match is the winner.
    always_comb begin
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand        = 0;
        if (MODE == ARB_FIXED) begin
            for (int unsigned i = NUM_CH; i >= 1; i--) begin
                if (req[i-1]) begin
                    grant_idx   = IDX_W'(i - 1);
                    grant_valid = 1'b1;
                end
            end
        end else begin
            for (int unsigned k = NUM_CH; k >= 1; k--) begin
                cand = (32'(last_grant) + k) % NUM_CH;
                if (req[cand]) begin
                    grant_idx   = IDX_W'(cand);
                    grant_valid = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Multi-channel arbiter in front of a single shared memory port; one
// transaction at a time through IDLE -> ISSUE -> WAIT -> DONE.
module mem_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned NUM_CH   = 2,
    parameter int unsigned ADDR_W   = 6,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ARB_MODE = ARB_RR
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic [NUM_CH-1:0]          ch_read,
    input  logic [NUM_CH-1:0]          ch_write,
    input  logic [NUM_CH*ADDR_W-1:0]   ch_address,
    input  logic [NUM_CH*DATA_W-1:0]   ch_writedata,
    output logic [DATA_W-1:0]          ch_readdata,
    output logic [NUM_CH-1:0]          ch_busywait,
    output logic                       mem_read,
    output logic                       mem_write,
    output logic [ADDR_W-1:0]          mem_address,
    output logic [DATA_W-1:0]          mem_writedata,
    input  logic [DATA_W-1:0]          mem_readdata,
    input  logic                       mem_busywait
);

    localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    arb_state_t        state;
    logic [IDX_W-1:0]  grant_idx;
    logic [IDX_W-1:0]  last_grant;
    logic [IDX_W-1:0]  sel_idx;
    logic              sel_valid;
    logic [NUM_CH-1:0] req;

    assign req = ch_read | ch_write;

    rr_select #(
        .NUM_CH (NUM_CH),
        .MODE   (ARB_MODE)
    ) u_sel (
        .req         (req),
        .last_grant  (last_grant),
        .grant_idx   (sel_idx),
        .grant_valid (sel_valid)
    );

    always_comb begin
        ch_busywait = req;
        if (state == DONE) begin
            ch_busywait[grant_idx] = 1'b0;
        end
    end

    // The memory request lines double as the latched operation; a channel
    // asserting both read and write is served as a write.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state         <= IDLE;
            grant_idx     <= '0;
            last_grant    <= IDX_W'(NUM_CH - 1);
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            mem_address   <= '0;
            mem_writedata <= '0;
            ch_readdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_valid) begin
                        grant_idx     <= sel_idx;
                        last_grant    <= sel_idx;
                        mem_address   <= ch_address[ADDR_W*32'(sel_idx) +: ADDR_W];
                        mem_writedata <= ch_writedata[DATA_W*32'(sel_idx) +: DATA_W];
                        mem_write     <= ch_write[sel_idx];
                        mem_read      <= ~ch_write[sel_idx];
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (!mem_busywait) begin
                        if (mem_read) begin
                            ch_readdata <= mem_readdata;
                        end
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: one round-robin and one fixed-priority instance,
// each with its own behavioural memory, plus directed and random scenarios.
module tb_mem_arbiter;
    import arb_pkg::*;

    localparam int NCH   = 4;
    localparam int AW    = 6;
    localparam int DW    = 32;
    localparam int DEPTH = 1 << AW;

    logic             CLK;
    logic             RESET;
    logic [NCH-1:0]   ch_read      [2];
    logic [NCH-1:0]   ch_write     [2];
    logic [NCH*AW-1:0] ch_address  [2];
    logic [NCH*DW-1:0] ch_writedata[2];
    logic [DW-1:0]    ch_readdata  [2];
    logic [NCH-1:0]   ch_busywait  [2];
    logic             mem_read     [2];
    logic             mem_write    [2];
    logic [AW-1:0]    mem_address  [2];
    logic [DW-1:0]    mem_writedata[2];
    logic [DW-1:0]    mem_readdata [2];
    logic             mem_busywait [2];

    logic [DW-1:0]    mem_array [2][DEPTH];
    int unsigned      mem_cnt   [2];
    int unsigned      mem_lat   [2];
    logic [DW-1:0]    ref_mem   [2][DEPTH];
    int               model_last[2];
    int               checks;
    int               errors;

    mem_arbiter #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(ARB_RR)) u_rr (
        .CLK(CLK), .RESET(RESET),
        .ch_read(ch_read[0]), .ch_write(ch_write[0]),
        .ch_address(ch_address[0]), .ch_writedata(ch_writedata[0]),
        .ch_readdata(ch_readdata[0]), .ch_busywait(ch_busywait[0]),
        .mem_read(mem_read[0]), .mem_write(mem_write[0]),
        .mem_address(mem_address[0]), .mem_writedata(mem_writedata[0]),
        .mem_readdata(mem_readdata[0]), .mem_busywait(mem_busywait[0])
    );

    mem_arbiter #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(ARB_FIXED)) u_fp (
        .CLK(CLK), .RESET(RESET),
        .ch_read(ch_read[1]), .ch_write(ch_write[1]),
        .ch_address(ch_address[1]), .ch_writedata(ch_writedata[1]),
        .ch_readdata(ch_readdata[1]), .ch_busywait(ch_busywait[1]),
        .mem_read(mem_read[1]), .mem_write(mem_write[1]),
        .mem_address(mem_address[1]), .mem_writedata(mem_writedata[1]),
        .mem_readdata(mem_readdata[1]), .mem_busywait(mem_busywait[1])
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic logic [DW-1:0] init_word(input int d, input int a);
        if (a == 5) return 32'hDEADBEEF;
        return {4'(d + 1), 12'h0, 10'(a), 6'(a)};
    endfunction

    // Memory: busy for mem_lat cycles starting the cycle after it first
    // sees a request; the access completes on the edge after busy drops.
    always_comb begin
        for (int d = 0; d < 2; d++) begin
            mem_busywait[d] = (mem_read[d] | mem_write[d]) && (mem_cnt[d] >= 1) && (mem_cnt[d] <= mem_lat[d]);
            mem_readdata[d] = mem_array[d][mem_address[d]];
        end
    end

    always @(posedge CLK or negedge RESET) begin
        for (int d = 0; d < 2; d++) begin
            if (!RESET) begin
                mem_cnt[d] <= 0;
                for (int a = 0; a < DEPTH; a++) mem_array[d][a] <= init_word(d, a);
            end else if (mem_read[d] | mem_write[d]) begin
                if (mem_write[d] && mem_cnt[d] == mem_lat[d] + 1)
                    mem_array[d][mem_address[d]] <= mem_writedata[d];
                mem_cnt[d] <= mem_cnt[d] + 1;
            end else begin
                mem_cnt[d] <= 0;
            end
        end
    end

    // Next winner among pending channels, straight from the arbitration rules.
    function automatic int pick(input logic [NCH-1:0] pend, input int last, input int mode);
        if (mode == 1) begin
            for (int i = 0; i < NCH; i++) if (pend[i]) return i;
        end else begin
            for (int k = 1; k <= NCH; k++) if (pend[(last + k) % NCH]) return (last + k) % NCH;
        end
        return -1;
    endfunction

    task automatic clear_inputs();
        for (int d = 0; d < 2; d++) begin
            ch_read[d]      = '0;
            ch_write[d]     = '0;
            ch_address[d]   = '0;
            ch_writedata[d] = '0;
        end
    endtask

    task automatic apply_reset();
        RESET = 1'b0;
        clear_inputs();
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        for (int d = 0; d < 2; d++) begin
            model_last[d] = NCH - 1;
            for (int a = 0; a < DEPTH; a++) ref_mem[d][a] = init_word(d, a);
        end
    endtask

    task automatic test_reset();
        RESET = 1'b0;
        clear_inputs();
        ch_read[0]    = 4'b0101;
        ch_write[1]   = 4'b1000;
        ch_address[0] = '1;
        repeat (2) @(negedge CLK);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (mem_read[d] !== 1'b0) begin errors++; $display("FAIL reset_mem_read[%0d]: got %b want 0", d, mem_read[d]); end
            checks++;
            if (mem_write[d] !== 1'b0) begin errors++; $display("FAIL reset_mem_write[%0d]: got %b want 0", d, mem_write[d]); end
            checks++;
            if (mem_address[d] !== '0) begin errors++; $display("FAIL reset_mem_address[%0d]: got %h want 0", d, mem_address[d]); end
            checks++;
            if (mem_writedata[d] !== '0) begin errors++; $display("FAIL reset_mem_writedata[%0d]: got %h want 0", d, mem_writedata[d]); end
            checks++;
            if (ch_readdata[d] !== '0) begin errors++; $display("FAIL reset_ch_readdata[%0d]: got %h want 0", d, ch_readdata[d]); end
        end
        checks++;
        if (ch_busywait[0] !== 4'b0101) begin errors++; $display("FAIL reset_busywait_rr: got %b want 0101", ch_busywait[0]); end
        checks++;
        if (ch_busywait[1] !== 4'b1000) begin errors++; $display("FAIL reset_busywait_fp: got %b want 1000", ch_busywait[1]); end
    endtask

    task automatic test_single_read();
        int cyc, hi, mem_fall, rel;
        logic [DW-1:0] rd;
        apply_reset();
        mem_lat[0] = 5;
        ch_address[0][0 +: AW] = 6'h05;
        ch_read[0][0] = 1'b1;
        cyc = 0; hi = 0; mem_fall = -1; rel = -1; rd = '0;
        while (rel < 0 && cyc < 40) begin
            @(negedge CLK);
            cyc++;
            if (mem_busywait[0]) hi++;
            else if (hi > 0 && mem_fall < 0) mem_fall = cyc;
            if (!ch_busywait[0][0]) begin rel = cyc; rd = ch_readdata[0]; end
        end
        ch_read[0][0] = 1'b0;
        checks++;
        if (rel != 8) begin errors++; $display("FAIL single_latency: got %0d want 8", rel); end
        checks++;
        if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL single_rdata: got %h want deadbeef", rd); end
        checks++;
        if (rel != mem_fall + 1) begin errors++; $display("FAIL single_release_vs_mem: got %0d want %0d", rel, mem_fall + 1); end
        checks++;
        if (hi != 5) begin errors++; $display("FAIL single_mem_busy_cycles: got %0d want 5", hi); end
    endtask

    task automatic test_simultaneous();
        int n, cyc, stall_bad;
        int seq [2];
        logic [DW-1:0] rdat [2];
        apply_reset();
        mem_lat[0] = 2;
        ch_address[0][0 +: AW]  = 6'h01;
        ch_address[0][AW +: AW] = 6'h02;
        ch_read[0] = 4'b0011;
        n = 0; cyc = 0; stall_bad = 0;
        seq[0] = -1; seq[1] = -1; rdat[0] = '0; rdat[1] = '0;
        while (n < 2 && cyc < 60) begin
            @(negedge CLK);
            cyc++;
            if (n == 0 && ch_busywait[0][1] !== 1'b1) stall_bad++;
            for (int i = 0; i < 2; i++) begin
                if (n < 2 && ch_read[0][i] && !ch_busywait[0][i]) begin
                    seq[n]  = i;
                    rdat[n] = ch_readdata[0];
                    n++;
                    ch_read[0][i] = 1'b0;
                end
            end
        end
        checks++;
        if (seq[0] != 0) begin errors++; $display("FAIL simul_first: got %0d want 0", seq[0]); end
        checks++;
        if (seq[1] != 1) begin errors++; $display("FAIL simul_second: got %0d want 1", seq[1]); end
        checks++;
        if (stall_bad != 0) begin errors++; $display("FAIL simul_ch1_stall: got %0d unstalled cycles want 0", stall_bad); end
        checks++;
        if (rdat[0] !== init_word(0, 1)) begin errors++; $display("FAIL simul_rdata0: got %h want %h", rdat[0], init_word(0, 1)); end
        checks++;
        if (rdat[1] !== init_word(0, 2)) begin errors++; $display("FAIL simul_rdata1: got %h want %h", rdat[1], init_word(0, 2)); end
    endtask

    task automatic test_fairness();
        int n, cyc;
        int seq [8];
        apply_reset();
        mem_lat[0] = 1;
        for (int i = 0; i < NCH; i++) ch_address[0][i*AW +: AW] = AW'($urandom);
        ch_read[0] = '1;
        n = 0; cyc = 0;
        for (int k = 0; k < 8; k++) seq[k] = -1;
        while (n < 8 && cyc < 200) begin
            @(negedge CLK);
            cyc++;
            for (int i = 0; i < NCH; i++)
                if (n < 8 && !ch_busywait[0][i]) begin seq[n] = i; n++; end
        end
        clear_inputs();
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (seq[k] != k % NCH) begin errors++; $display("FAIL fair_order[%0d]: got %0d want %0d", k, seq[k], k % NCH); end
        end
    endtask

    task automatic test_fixed_priority();
        int n, cyc;
        int seq [3];
        logic [DW-1:0] rd2;
        apply_reset();
        mem_lat[1] = 4;
        ch_address[1][2*AW +: AW] = 6'h07;
        ch_read[1][2] = 1'b1;
        repeat (2) @(negedge CLK);
        checks++;
        if (mem_read[1] !== 1'b1) begin errors++; $display("FAIL fixed_ch2_active: got %b want 1", mem_read[1]); end
        ch_read[1][0]  = 1'b1;
        ch_write[1][3] = 1'b1;
        n = 0; cyc = 0; rd2 = '0;
        for (int k = 0; k < 3; k++) seq[k] = -1;
        while (n < 3 && cyc < 80) begin
            @(negedge CLK);
            cyc++;
            for (int i = 0; i < NCH; i++) begin
                if (n < 3 && (ch_read[1][i] | ch_write[1][i]) && !ch_busywait[1][i]) begin
                    seq[n] = i;
                    n++;
                    if (i == 2) rd2 = ch_readdata[1];
                    ch_read[1][i]  = 1'b0;
                    ch_write[1][i] = 1'b0;
                end
            end
        end
        checks++;
        if (seq[0] != 2) begin errors++; $display("FAIL fixed_first: got %0d want 2", seq[0]); end
        checks++;
        if (seq[1] != 0) begin errors++; $display("FAIL fixed_second: got %0d want 0", seq[1]); end
        checks++;
        if (seq[2] != 3) begin errors++; $display("FAIL fixed_third: got %0d want 3", seq[2]); end
        checks++;
        if (rd2 !== init_word(1, 7)) begin errors++; $display("FAIL fixed_rdata: got %h want %h", rd2, init_word(1, 7)); end
    endtask

    task automatic test_reset_mid_wait();
        int cyc, rel;
        apply_reset();
        mem_lat[0] = 6;
        ch_address[0][AW +: AW]   = 6'h11;
        ch_writedata[0][DW +: DW] = 32'hCAFE0011;
        ch_write[0][1] = 1'b1;
        repeat (3) @(negedge CLK);
        checks++;
        if (mem_write[0] !== 1'b1) begin errors++; $display("FAIL rstmid_pre_write: got %b want 1", mem_write[0]); end
        RESET = 1'b0;
        #1;
        checks++;
        if (mem_write[0] !== 1'b0) begin errors++; $display("FAIL rstmid_write_async: got %b want 0", mem_write[0]); end
        checks++;
        if (mem_address[0] !== '0) begin errors++; $display("FAIL rstmid_addr_async: got %h want 0", mem_address[0]); end
        checks++;
        if (ch_busywait[0] !== 4'b0010) begin errors++; $display("FAIL rstmid_no_release: got %b want 0010", ch_busywait[0]); end
        @(negedge CLK);
        RESET = 1'b1;
        cyc = 0; rel = -1;
        while (rel < 0 && cyc < 40) begin
            @(negedge CLK);
            cyc++;
            if (!ch_busywait[0][1]) rel = cyc;
        end
        clear_inputs();
        checks++;
        if (rel != 9) begin errors++; $display("FAIL rstmid_fresh_latency: got %0d want 9", rel); end
        checks++;
        if (mem_array[0][6'h11] !== 32'hCAFE0011) begin errors++; $display("FAIL rstmid_mem_written: got %h want cafe0011", mem_array[0][6'h11]); end
    endtask

    task automatic test_post_grant_change();
        int cyc, rel, bad;
        apply_reset();
        mem_lat[0] = 3;
        ch_address[0][0 +: AW]   = 6'h3F;
        ch_writedata[0][0 +: DW] = 32'h12345678;
        ch_write[0][0] = 1'b1;
        cyc = 0; rel = -1; bad = 0;
        while (rel < 0 && cyc < 40) begin
            @(negedge CLK);
            cyc++;
            if (mem_write[0] && (mem_address[0] !== 6'h3F || mem_writedata[0] !== 32'h12345678)) bad++;
            if (cyc == 2) begin
                ch_address[0][0 +: AW]   = 6'h00;
                ch_writedata[0][0 +: DW] = 32'hFFFF0000;
            end
            if (!ch_busywait[0][0]) rel = cyc;
        end
        ch_write[0][0] = 1'b0;
        @(negedge CLK);
        checks++;
        if (bad != 0) begin errors++; $display("FAIL postgrant_mem_view: got %0d bad cycles want 0", bad); end
        checks++;
        if (rel != 6) begin errors++; $display("FAIL postgrant_latency: got %0d want 6", rel); end
        checks++;
        if (mem_address[0] !== 6'h3F || mem_writedata[0] !== 32'h12345678)
            begin errors++; $display("FAIL postgrant_hold: got %h/%h want 3f/12345678", mem_address[0], mem_writedata[0]); end
        checks++;
        if (mem_array[0][6'h3F] !== 32'h12345678) begin errors++; $display("FAIL postgrant_mem_3f: got %h want 12345678", mem_array[0][6'h3F]); end
        checks++;
        if (mem_array[0][0] !== init_word(0, 0)) begin errors++; $display("FAIL postgrant_mem_00: got %h want %h", mem_array[0][0], init_word(0, 0)); end
    endtask

    task automatic run_batch(input int d, input int mode);
        logic [NCH-1:0] pend;
        bit             op_wr [NCH];
        logic [AW-1:0]  addr  [NCH];
        logic [DW-1:0]  wdata [NCH];
        logic [DW-1:0]  exp_rd;
        int             kind, exp_ch, left, cyc;
        pend = NCH'($urandom_range(1, (1 << NCH) - 1));
        mem_lat[d] = $urandom_range(0, 3);
        for (int i = 0; i < NCH; i++) begin
            op_wr[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
            if (pend[i]) begin
                kind     = $urandom_range(0, 2);
                op_wr[i] = (kind != 0);
                addr[i]  = AW'($urandom);
                wdata[i] = $urandom;
                ch_read[d][i]  = (kind != 1);
                ch_write[d][i] = (kind != 0);
                ch_address[d][i*AW +: AW]   = addr[i];
                ch_writedata[d][i*DW +: DW] = wdata[i];
            end
        end
        left   = $countones(pend);
        exp_ch = pick(pend, model_last[d], mode);
        exp_rd = '0;
        cyc    = 0;
        while (left > 0 && cyc < 400) begin
            @(negedge CLK);
            cyc++;
            if ((mem_read[d] | mem_write[d]) && !mem_busywait[d] && mem_cnt[d] >= 1) begin
                checks++;
                if (mem_write[d] !== op_wr[exp_ch] || mem_address[d] !== addr[exp_ch] ||
                    (op_wr[exp_ch] && mem_writedata[d] !== wdata[exp_ch])) begin
                    errors++;
                    $display("FAIL rand_mem_txn[%0d]: got wr=%b addr=%h data=%h want wr=%b addr=%h data=%h",
                             d, mem_write[d], mem_address[d], mem_writedata[d], op_wr[exp_ch], addr[exp_ch], wdata[exp_ch]);
                end
                if (op_wr[exp_ch]) ref_mem[d][addr[exp_ch]] = wdata[exp_ch];
                else exp_rd = ref_mem[d][addr[exp_ch]];
            end
            for (int i = 0; i < NCH; i++) begin
                if (pend[i] && !ch_busywait[d][i]) begin
                    checks++;
                    if (i != exp_ch) begin errors++; $display("FAIL rand_grant[%0d]: got ch%0d want ch%0d", d, i, exp_ch); end
                    if (!op_wr[i]) begin
                        checks++;
                        if (ch_readdata[d] !== exp_rd) begin errors++; $display("FAIL rand_rdata[%0d]: got %h want %h", d, ch_readdata[d], exp_rd); end
                    end
                    ch_read[d][i]  = 1'b0;
                    ch_write[d][i] = 1'b0;
                    pend[i]        = 1'b0;
                    left--;
                    model_last[d]  = exp_ch;
                    if (left > 0) exp_ch = pick(pend, model_last[d], mode);
                end
            end
        end
        checks++;
        if (left != 0) begin errors++; $display("FAIL rand_timeout[%0d]: got %0d pending want 0", d, left); end
        clear_inputs();
    endtask

    task automatic test_random();
        apply_reset();
        for (int b = 0; b < 12; b++) run_batch(0, 0);
        for (int b = 0; b < 8; b++) run_batch(1, 1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        RESET  = 1'b0;
        clear_inputs();
        mem_lat[0] = 1;
        mem_lat[1] = 1;
        model_last[0] = NCH - 1;
        model_last[1] = NCH - 1;
        test_reset();
        test_single_read();
        test_simultaneous();
        test_fairness();
        test_fixed_priority();
        test_reset_mid_wait();
        test_post_grant_change();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
